// File: rtl/fetch_pfq.sv
// fetch_pfq: instruction prefetch queue between the I-Port and decode.
// It issues sequential fetches ahead of the decoder and holds up to DEPTH
// instructions, each with its PC and error tags. A flush (redirect)
// discards the queue and any response that is still in flight.
// Optional feature: define FETCH_PFQ_BYPASS_EN so that a response arriving
// at an empty queue is presented on o_* in the same cycle it arrives.
module fetch_pfq #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = {ADDR_WIDTH{1'b0}},
    parameter int                    INSTR_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_flush,
    input  logic [ADDR_WIDTH-1:0] i_flush_addr,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_err_bus,
    output logic                  o_err_align,
    output logic [ADDR_WIDTH-1:0] o_IAddr,
    output logic                  o_IRdC,
    input  logic [DATA_WIDTH-1:0] i_IData,
    input  logic                  i_IRdy,
    input  logic                  i_IErr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0]      PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] INSTR_INC  = ADDR_WIDTH'(INSTR_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_SIZE - 1);

    // FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;  // no request outstanding
    localparam logic [1:0] ST_REQ     = 2'd1;  // request outstanding, response kept
    localparam logic [1:0] ST_HALT    = 2'd2;  // error seen, wait for redirect
    localparam logic [1:0] ST_DISCARD = 2'd3;  // request outstanding, response dropped

    // An address is misaligned when any of its log2(INSTR_SIZE) low bits is set.
    function automatic logic misaligned_f(input logic [ADDR_WIDTH-1:0] addr);
        return ((addr & ALIGN_MASK) != ADDR_ZERO);
    endfunction

    // State
    logic [1:0]            state_r;
    logic [ADDR_WIDTH-1:0] fetch_pc_r;
    logic [CNT_W-1:0]      count_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;

    logic [DATA_WIDTH-1:0] data_mem_r  [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_r    [DEPTH];
    logic                  ebus_mem_r  [DEPTH];
    logic                  ealign_mem_r[DEPTH];

    // Next-state values
    logic [1:0]            state_nx_s;
    logic [ADDR_WIDTH-1:0] fetch_pc_nx_s;
    logic [ADDR_WIDTH-1:0] iaddr_nx_s;
    logic                  irdc_nx_s;

    // Push request and its payload
    logic                  push_s;
    logic [DATA_WIDTH-1:0] push_data_s;
    logic [ADDR_WIDTH-1:0] push_pc_s;
    logic                  push_ebus_s;
    logic                  push_ealign_s;

    logic                  resp_s;
    logic                  byp_s;
    logic                  byp_take_s;
    logic                  q_push_s;
    logic                  q_pop_s;
    logic [CNT_W-1:0]      count_after_s;
    logic                  space_s;
    logic [ADDR_WIDTH-1:0] next_pc_s;

    // A response completes in any cycle the outstanding command sees Rdy or Err.
    assign resp_s    = o_IRdC & (i_IRdy | i_IErr);
    assign next_pc_s = o_IAddr + INSTR_INC;

`ifdef FETCH_PFQ_BYPASS_EN
    // Kept data response arriving at an empty queue drives the head directly.
    assign byp_s = (state_r == ST_REQ) & o_IRdC & i_IRdy & ~i_IErr & ~i_flush
                 & (count_r == CNT_ZERO);
`else
    assign byp_s = 1'b0;
`endif
    assign byp_take_s = byp_s & i_ready;

    // A bypassed entry consumed the same cycle never enters the queue.
    assign q_push_s      = push_s & ~byp_take_s;
    assign q_pop_s       = (count_r != CNT_ZERO) & i_ready & ~i_flush;
    assign count_after_s = count_r + {{PTR_W{1'b0}}, q_push_s} - {{PTR_W{1'b0}}, q_pop_s};
    // A new request needs a free slot for its response after this cycle's push/pop.
    assign space_s       = (count_after_s < DEPTH_C);

    // Decode which entry (if any) is pushed this cycle.
    always_comb begin
        push_s        = 1'b0;
        push_data_s   = DATA_ZERO;
        push_pc_s     = ADDR_ZERO;
        push_ebus_s   = 1'b0;
        push_ealign_s = 1'b0;
        if (i_flush) begin
            push_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (misaligned_f(fetch_pc_r)) begin
                        push_s        = 1'b1;
                        push_pc_s     = fetch_pc_r;
                        push_ealign_s = 1'b1;
                    end else begin
                        push_s = 1'b0;
                    end
                end
                ST_REQ: begin
                    if (resp_s) begin
                        push_s    = 1'b1;
                        push_pc_s = o_IAddr;
                        if (i_IErr) begin
                            push_ebus_s = 1'b1;
                        end else begin
                            push_data_s = i_IData;
                        end
                    end else begin
                        push_s = 1'b0;
                    end
                end
                default: begin
                    push_s = 1'b0;
                end
            endcase
        end
    end

    // Fetch FSM: next state, next fetch PC and next I-Port command.
    always_comb begin
        state_nx_s    = state_r;
        fetch_pc_nx_s = fetch_pc_r;
        iaddr_nx_s    = o_IAddr;
        irdc_nx_s     = o_IRdC;
        if (i_flush) begin
            fetch_pc_nx_s = i_flush_addr;
            if (o_IRdC && !resp_s) begin
                // Request still pending: hold the command, drop its response later.
                state_nx_s = ST_DISCARD;
            end else begin
                state_nx_s = ST_IDLE;
                irdc_nx_s  = 1'b0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (misaligned_f(fetch_pc_r)) begin
                        state_nx_s = ST_HALT;
                    end else if (space_s) begin
                        irdc_nx_s  = 1'b1;
                        iaddr_nx_s = fetch_pc_r;
                        state_nx_s = ST_REQ;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (resp_s && i_IErr) begin
                        irdc_nx_s  = 1'b0;
                        state_nx_s = ST_HALT;
                    end else if (resp_s) begin
                        fetch_pc_nx_s = next_pc_s;
                        if (space_s && !misaligned_f(next_pc_s)) begin
                            // Back-to-back: one fetch per cycle from zero-wait memory.
                            iaddr_nx_s = next_pc_s;
                        end else begin
                            irdc_nx_s  = 1'b0;
                            state_nx_s = ST_IDLE;
                        end
                    end else begin
                        state_nx_s = ST_REQ;
                    end
                end
                ST_HALT: begin
                    state_nx_s = ST_HALT;
                end
                ST_DISCARD: begin
                    if (resp_s) begin
                        irdc_nx_s  = 1'b0;
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_DISCARD;
                    end
                end
                default: begin
                    irdc_nx_s  = 1'b0;
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM, fetch PC and registered I-Port command.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_ADDR;
            o_IAddr    <= RESET_ADDR;
            o_IRdC     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            fetch_pc_r <= fetch_pc_nx_s;
            o_IAddr    <= iaddr_nx_s;
            o_IRdC     <= irdc_nx_s;
        end
    end

    // Circular entry store with wrap-around pointers and occupancy count.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i]   <= DATA_ZERO;
                pc_mem_r[i]     <= ADDR_ZERO;
                ebus_mem_r[i]   <= 1'b0;
                ealign_mem_r[i] <= 1'b0;
            end
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (i_flush) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (q_push_s) begin
                data_mem_r[wr_ptr_r]   <= push_data_s;
                pc_mem_r[wr_ptr_r]     <= push_pc_s;
                ebus_mem_r[wr_ptr_r]   <= push_ebus_s;
                ealign_mem_r[wr_ptr_r] <= push_ealign_s;
                wr_ptr_r               <= wr_ptr_r + PTR_ONE;
            end
            if (q_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_after_s;
        end
    end

    // Head presentation; all head fields read as zero when nothing is valid.
    always_comb begin
        o_valid     = 1'b0;
        o_instr     = DATA_ZERO;
        o_pc        = ADDR_ZERO;
        o_err_bus   = 1'b0;
        o_err_align = 1'b0;
        if (byp_s) begin
            o_valid = 1'b1;
            o_instr = i_IData;
            o_pc    = o_IAddr;
        end else if (count_r != CNT_ZERO) begin
            o_valid     = 1'b1;
            o_instr     = data_mem_r[rd_ptr_r];
            o_pc        = pc_mem_r[rd_ptr_r];
            o_err_bus   = ebus_mem_r[rd_ptr_r];
            o_err_align = ealign_mem_r[rd_ptr_r];
        end else begin
            o_valid = 1'b0;
        end
    end

endmodule
